// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, control gating on empty, and saturating stall/flush counters.
module ex_mem_skid_reg #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int FUNC_W  = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_addsum,
    input  logic [XLEN-1:0]    in_alu_res,
    input  logic               in_zero,
    input  logic               in_is_greater,
    input  logic [XLEN-1:0]    in_rd2,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_regwrite,
    input  logic               in_memtoreg,
    input  logic               in_branch,
    input  logic               in_memread,
    input  logic               in_memwrite,
    input  logic [FUNC_W-1:0]  in_func,
    input  logic [XLEN-1:0]    in_write_data,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_addsum,
    output logic [XLEN-1:0]    out_alu_res,
    output logic               out_zero,
    output logic               out_is_greater,
    output logic [XLEN-1:0]    out_rd2,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_regwrite,
    output logic               out_memtoreg,
    output logic               out_branch,
    output logic               out_memread,
    output logic               out_memwrite,
    output logic [FUNC_W-1:0]  out_func,
    output logic [XLEN-1:0]    out_write_data,

    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]    addsum;
        logic [XLEN-1:0]    alu_res;
        logic               zero;
        logic               is_greater;
        logic [XLEN-1:0]    rd2;
        logic [RADDR_W-1:0] rd;
        logic               regwrite;
        logic               memtoreg;
        logic               branch;
        logic               memread;
        logic               memwrite;
        logic [FUNC_W-1:0]  func;
        logic [XLEN-1:0]    write_data;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    payload_t in_pl;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    logic     main_valid_q, main_valid_d;
    logic     skid_valid_q, skid_valid_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic accept;
    logic fire;
    logic stalled;

    assign in_pl = '{
        addsum:     in_addsum,
        alu_res:    in_alu_res,
        zero:       in_zero,
        is_greater: in_is_greater,
        rd2:        in_rd2,
        rd:         in_rd,
        regwrite:   in_regwrite,
        memtoreg:   in_memtoreg,
        branch:     in_branch,
        memread:    in_memread,
        memwrite:   in_memwrite,
        func:       in_func,
        write_data: in_write_data
    };

    // in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;
    assign fire     = main_valid_q & out_ready;
    assign stalled  = main_valid_q & ~out_ready;

    always_comb begin
        // NOTE: every target gets a default first so no path through this block infers a latch.
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_d       = '0;
            skid_d       = '0;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || fire) begin
            // Main slot is free (or being vacated): oldest entry moves in first.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_pl;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (stalled && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload flops are reset too, so out_* read as zero straight after reset.
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign out_valid      = main_valid_q;
    assign out_addsum     = main_q.addsum;
    assign out_alu_res    = main_q.alu_res;
    assign out_zero       = main_q.zero;
    assign out_is_greater = main_q.is_greater;
    assign out_rd2        = main_q.rd2;
    assign out_rd         = main_q.rd;
    assign out_func       = main_q.func;
    assign out_write_data = main_q.write_data;

    // Control gated with valid so an empty stage never writes the register file or memory.
    assign out_regwrite   = main_q.regwrite & main_valid_q;
    assign out_memtoreg   = main_q.memtoreg & main_valid_q;
    assign out_branch     = main_q.branch   & main_valid_q;
    assign out_memread    = main_q.memread  & main_valid_q;
    assign out_memwrite   = main_q.memwrite & main_valid_q;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_ex_mem_skid_reg;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;
    localparam int FUNC_W  = 4;
    localparam int CNT_W   = 4;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [XLEN-1:0]    addsum;
        logic [XLEN-1:0]    alu_res;
        logic               zero;
        logic               is_greater;
        logic [XLEN-1:0]    rd2;
        logic [RADDR_W-1:0] rd;
        logic               regwrite;
        logic               memtoreg;
        logic               branch;
        logic               memread;
        logic               memwrite;
        logic [FUNC_W-1:0]  func;
        logic [XLEN-1:0]    write_data;
    } pl_t;

    logic clk = 1'b0;
    logic reset_n, flush, in_valid, out_ready;
    pl_t  in_pl;

    logic               in_ready, out_valid;
    logic [XLEN-1:0]    out_addsum, out_alu_res, out_rd2, out_write_data;
    logic               out_zero, out_is_greater;
    logic [RADDR_W-1:0] out_rd;
    logic               out_regwrite, out_memtoreg, out_branch, out_memread, out_memwrite;
    logic [FUNC_W-1:0]  out_func;
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;
    pl_t                out_pl;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the stage is a FIFO of capacity 2; "shown" is what main displays.
    pl_t         q[$];
    pl_t         shown;
    int unsigned m_stall, m_flush;

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .FUNC_W(FUNC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addsum(in_pl.addsum), .in_alu_res(in_pl.alu_res),
        .in_zero(in_pl.zero), .in_is_greater(in_pl.is_greater),
        .in_rd2(in_pl.rd2), .in_rd(in_pl.rd),
        .in_regwrite(in_pl.regwrite), .in_memtoreg(in_pl.memtoreg),
        .in_branch(in_pl.branch), .in_memread(in_pl.memread), .in_memwrite(in_pl.memwrite),
        .in_func(in_pl.func), .in_write_data(in_pl.write_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addsum(out_addsum), .out_alu_res(out_alu_res),
        .out_zero(out_zero), .out_is_greater(out_is_greater),
        .out_rd2(out_rd2), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
        .out_branch(out_branch), .out_memread(out_memread), .out_memwrite(out_memwrite),
        .out_func(out_func), .out_write_data(out_write_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign out_pl = '{
        addsum: out_addsum, alu_res: out_alu_res, zero: out_zero, is_greater: out_is_greater,
        rd2: out_rd2, rd: out_rd, regwrite: out_regwrite, memtoreg: out_memtoreg,
        branch: out_branch, memread: out_memread, memwrite: out_memwrite,
        func: out_func, write_data: out_write_data
    };

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pl_t mk(input logic [63:0] v);
        pl_t p;
        p.addsum     = v + 64'd4;
        p.alu_res    = v;
        p.zero       = v[0];
        p.is_greater = v[1];
        p.rd2        = ~v;
        p.rd         = v[4:0];
        p.regwrite   = 1'b1;
        p.memtoreg   = 1'b1;
        p.branch     = 1'b1;
        p.memread    = 1'b1;
        p.memwrite   = 1'b1;
        p.func       = v[7:4];
        p.write_data = {v[31:0], v[63:32]};
        return p;
    endfunction

    function automatic pl_t rnd_pl();
        pl_t p;
        p.addsum     = {$urandom, $urandom};
        p.alu_res    = {$urandom, $urandom};
        p.zero       = 1'($urandom);
        p.is_greater = 1'($urandom);
        p.rd2        = {$urandom, $urandom};
        p.rd         = RADDR_W'($urandom);
        p.regwrite   = 1'($urandom);
        p.memtoreg   = 1'($urandom);
        p.branch     = 1'($urandom);
        p.memread    = 1'($urandom);
        p.memwrite   = 1'($urandom);
        p.func       = FUNC_W'($urandom);
        p.write_data = {$urandom, $urandom};
        return p;
    endfunction

    // Advance the model by one clock edge using the inputs currently being driven.
    task automatic model_edge();
        int n = q.size();
        if (!reset_n) begin
            q.delete();
            shown   = '0;
            m_stall = 0;
            m_flush = 0;
        end else if (flush) begin
            if (n > 0 && m_flush < CMAX) m_flush++;
            q.delete();
            shown = '0;
        end else begin
            if (n > 0 && !out_ready && m_stall < CMAX) m_stall++;
            if (n > 0 && out_ready) shown = q.pop_front();
            if (in_valid && n < 2) q.push_back(in_pl);
            if (q.size() > 0) shown = q[0];
        end
    endtask

    task automatic check_all();
        pl_t exp_pl;
        logic v;
        v = (q.size() > 0);
        exp_pl = shown;
        exp_pl.regwrite = shown.regwrite & v;
        exp_pl.memtoreg = shown.memtoreg & v;
        exp_pl.branch   = shown.branch   & v;
        exp_pl.memread  = shown.memread  & v;
        exp_pl.memwrite = shown.memwrite & v;
        check("out_valid", 512'(out_valid), 512'(v));
        check("in_ready",  512'(in_ready),  512'(q.size() < 2));
        check("out_pl",    512'(out_pl),    512'(exp_pl));
        check("stall_cnt", 512'(stall_cnt), 512'(m_stall));
        check("flush_cnt", 512'(flush_cnt), 512'(m_flush));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic iv, input pl_t p, input logic ordy, input logic fl);
        in_valid  = iv;
        in_pl     = p;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        q.delete();
        shown   = '0;
        m_stall = 0;
        m_flush = 0;

        // Reset state
        do_reset();
        check("rst_in_ready", 512'(in_ready), 512'(1'b1));
        check("rst_out_pl", 512'(out_pl), 512'(0));

        // Single transfer, 1-cycle latency
        drive(1'b1, mk(64'h1234), 1'b1, 1'b0);
        step();
        check("t1_valid", 512'(out_valid), 512'(1'b1));
        check("t1_alu", 512'(out_alu_res), 512'(64'h1234));
        check("t1_stall", 512'(stall_cnt), 512'(0));
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        // Back-to-back stream A,B,C
        drive(1'b1, mk(64'hA), 1'b1, 1'b0); step();
        check("t2_a", 512'(out_alu_res), 512'(64'hA));
        drive(1'b1, mk(64'hB), 1'b1, 1'b0); step();
        check("t2_b", 512'(out_alu_res), 512'(64'hB));
        drive(1'b1, mk(64'hC), 1'b1, 1'b0); step();
        check("t2_c", 512'(out_alu_res), 512'(64'hC));
        check("t2_ready", 512'(in_ready), 512'(1'b1));
        drive(1'b0, '0, 1'b1, 1'b0); step();

        // Backpressure: A in main, B in skid, C refused, then drain in order
        do_reset();
        drive(1'b1, mk(64'hA), 1'b0, 1'b0); step();
        drive(1'b1, mk(64'hB), 1'b0, 1'b0); step();
        check("t3_ready0", 512'(in_ready), 512'(1'b0));
        check("t3_main_a", 512'(out_alu_res), 512'(64'hA));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(64'hC), 1'b0, 1'b0); step();
        end
        check("t3_stall", 512'(stall_cnt), 512'(4));
        drive(1'b1, mk(64'hC), 1'b1, 1'b0); step();
        check("t3_b", 512'(out_alu_res), 512'(64'hB));
        drive(1'b1, mk(64'hC), 1'b1, 1'b0); step();
        check("t3_c", 512'(out_alu_res), 512'(64'hC));
        drive(1'b0, '0, 1'b1, 1'b0); step();
        check("t3_empty", 512'(out_valid), 512'(1'b0));

        // Flush with skid full and an incoming D
        drive(1'b1, mk(64'h11), 1'b0, 1'b0); step();
        drive(1'b1, mk(64'h22), 1'b0, 1'b0); step();
        drive(1'b1, mk(64'hD), 1'b1, 1'b1); step();
        check("t4_valid", 512'(out_valid), 512'(1'b0));
        check("t4_memwrite", 512'(out_memwrite), 512'(1'b0));
        check("t4_ready", 512'(in_ready), 512'(1'b1));
        check("t4_flush_cnt", 512'(flush_cnt), 512'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();

        // Flush on empty stage, then reset together with flush
        do_reset();
        drive(1'b0, '0, 1'b1, 1'b1); step();
        check("t5_flush_empty", 512'(flush_cnt), 512'(0));
        drive(1'b1, mk(64'h55), 1'b0, 1'b0); step();
        drive(1'b1, mk(64'h66), 1'b0, 1'b0); step();
        reset_n = 1'b0;
        drive(1'b1, mk(64'h77), 1'b0, 1'b1); step();
        check("t5_rst_valid", 512'(out_valid), 512'(1'b0));
        check("t5_rst_pl", 512'(out_pl), 512'(0));
        check("t5_rst_cnts", 512'({stall_cnt, flush_cnt}), 512'(0));
        reset_n = 1'b1;

        // Stall counter saturation
        drive(1'b1, mk(64'h99), 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check("t6_sat", 512'(stall_cnt), 512'(15));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 9) < 6), rnd_pl(), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 39) == 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
